// File: rtl/mac_job_sequencer_if.sv
// Job, operand, MAC-side and result signals of the MAC job sequencer.
// The slave modport is the sequencer. The master modport is whoever issues jobs and
// operands, takes results and returns the MAC accumulator.
interface mac_job_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              job_valid;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              mac_rst;
    logic              mac_en;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [DATA_W-1:0] mac_acc;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;

    modport master (
        output job_valid, job_len, op_valid, op_a, op_b, res_ready, mac_acc,
        input  job_ready, op_ready, mac_rst, mac_en, mac_a, mac_b, res_valid, res_data, busy
    );

    modport slave (
        input  job_valid, job_len, op_valid, op_a, op_b, res_ready, mac_acc,
        output job_ready, op_ready, mac_rst, mac_en, mac_a, mac_b, res_valid, res_data, busy
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// Control and feed stage for one mac_unit. It accepts a dot-product job and clears the MAC.
// It streams operand pairs into the MAC, issuing zero operands on bubbles. It then waits
// for the MAC pipeline to drain and presents the accumulator as a valid/ready result.
module mac_job_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned MAC_LATENCY = 3
) (
    input logic               clk,
    input logic               rst,
    mac_job_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAC_LATENCY + 2);
    // One extra count so the capture happens after acc reflects the last issued pair.
    localparam logic [CntW-1:0] DrainLoad = CntW'(MAC_LATENCY + 1);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StHold} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CntW-1:0]   drain_cnt_q, drain_cnt_d;
    logic              mac_rst_q, mac_rst_d;
    logic              mac_en_q, mac_en_d;
    logic [DATA_W-1:0] mac_a_q, mac_a_d;
    logic [DATA_W-1:0] mac_b_q, mac_b_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        drain_cnt_d = drain_cnt_q;
        mac_rst_d   = mac_rst_q;
        mac_en_d    = mac_en_q;
        // Zero operands unless a pair is handed over, so held products never re-accumulate.
        mac_a_d     = '0;
        mac_b_d     = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            StIdle: begin
                mac_rst_d = 1'b0;
                if (bus.job_valid) begin
                    rem_d     = bus.job_len;
                    mac_rst_d = 1'b1;
                    mac_en_d  = 1'b1;
                    state_d   = StClear;
                end
            end
            StClear: begin
                mac_rst_d = 1'b0;
                if (rem_q == '0) begin
                    drain_cnt_d = DrainLoad;
                    state_d     = StDrain;
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (bus.op_valid) begin
                    mac_a_d = bus.op_a;
                    mac_b_d = bus.op_b;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        drain_cnt_d = DrainLoad;
                        state_d     = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    res_data_d  = bus.mac_acc;
                    res_valid_d = 1'b1;
                    mac_en_d    = 1'b0;
                    state_d     = StHold;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset leaves mac_rst high so the MAC is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            drain_cnt_q <= '0;
            mac_rst_q   <= 1'b1;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_cnt_q <= drain_cnt_d;
            mac_rst_q   <= mac_rst_d;
            mac_en_q    <= mac_en_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.job_ready = (state_q == StIdle);
    assign bus.op_ready  = (state_q == StStream);
    assign bus.busy      = (state_q != StIdle);
    assign bus.mac_rst   = mac_rst_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

endmodule
